// File: rtl/rs232_pkg.sv
// Shared types and bit positions for the RS232 receive controller.
package rs232_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_e;

  localparam int CTRL_FSEL   = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_CLROVR = 2;
  localparam int CTRL_IE     = 3;

  localparam int ST_OVR    = 7;
  localparam int ST_FULL   = 6;
  localparam int ST_NEMPTY = 5;

endpackage

// File: rtl/rs232_rx_fifo.sv
// First-word-fall-through byte FIFO with flush; head reads as 8'h00 when empty.
module rs232_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [7:0] rdata_o,
  output logic [4:0] count_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       push_ok_o
);

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [4:0]    count_q, count_d;
  logic          do_push, do_pop;

  // A pop on a full FIFO frees the slot the concurrent push lands in.
  assign do_pop    = pop_i & (count_q != 5'd0);
  assign do_push   = push_i & ((count_q != DEPTH_C) | do_pop);
  assign push_ok_o = do_push;

  assign empty_o = (count_q == 5'd0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = empty_o ? 8'h00 : mem_q[rptr_q];

  // Next pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = 5'd0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + 5'(do_push) - 5'(do_pop);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= 5'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rs232_rx_ctrl.sv
// Receive-side controller: acks receiver bytes, buffers them, and exposes
// a control/status register with sticky overrun and maskable interrupt.
module rs232_rx_ctrl
  import rs232_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       rx_done,
  output logic       fsel,
  input  logic       rd,
  output logic [7:0] rd_data,
  input  logic       ctrl_wr,
  input  logic [3:0] ctrl_wdata,
  output logic [7:0] status,
  output logic       irq
);

  rx_state_e  state_q, state_d;
  logic       fsel_q, fsel_d;
  logic       ie_q, ie_d;
  logic       ovr_q, ovr_d;
  logic       push, push_ok, flush, clr_ovr;
  logic [4:0] count;
  logic       full, empty;

  assign flush   = ctrl_wr & ctrl_wdata[CTRL_FLUSH];
  assign clr_ovr = ctrl_wr & ctrl_wdata[CTRL_CLROVR];

  // Ack FSM: take the byte on entry, then hold done until rdy falls.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    rx_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          push    = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        rx_done = 1'b1;
        if (!rx_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control register and sticky overrun; a new overrun beats a clear, a flush beats both.
  always_comb begin
    fsel_d = fsel_q;
    ie_d   = ie_q;
    ovr_d  = ovr_q;
    if (ctrl_wr) begin
      fsel_d = ctrl_wdata[CTRL_FSEL];
      ie_d   = ctrl_wdata[CTRL_IE];
    end
    if (clr_ovr) ovr_d = 1'b0;
    if (flush)                ovr_d = 1'b0;
    else if (push && !push_ok) ovr_d = 1'b1;
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      fsel_q  <= 1'b0;
      ie_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fsel_q  <= fsel_d;
      ie_q    <= ie_d;
      ovr_q   <= ovr_d;
    end
  end

  rs232_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (rst),
    .push_i    (push),
    .wdata_i   (rx_data),
    .pop_i     (rd),
    .flush_i   (flush),
    .rdata_o   (rd_data),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty),
    .push_ok_o (push_ok)
  );

  assign fsel   = fsel_q;
  assign irq    = ie_q & ~empty;
  assign status = {ovr_q, full, ~empty, count};

endmodule

// File: doc/rs232_rx_ctrl.md
# rs232_rx_ctrl

Receive-side controller for the RS232 receiver (25 MHz system clock). Acknowledges each received byte through the receiver's `rdy`/`done` handshake, buffers bytes in a first-word-fall-through FIFO, and drives the receiver's baud select. Provides a CPU-facing control and status register with a sticky overrun flag and a maskable interrupt. Sits between the receiver and the I/O register decode.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, 2..16.
- `AW`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-low reset.
- `rx_rdy`  in  1  receiver "byte available" (its `rdy`).
- `rx_data`  in  8  receiver byte (its `data`); valid while `rx_rdy`=1.
- `rx_done`  out  1  to receiver `done`; "byte has been read".
- `fsel`  out  1  to receiver `fsel`; 1 = 115200 bps, 0 = 19200 bps.
- `rd`  in  1  CPU pop strobe, one cycle per byte.
- `rd_data`  out  8  FIFO head, combinational (FWFT); 8'h00 when empty.
- `ctrl_wr`  in  1  control register write strobe.
- `ctrl_wdata`  in  4  bit0 `fsel`, bit1 flush, bit2 clear overrun, bit3 interrupt enable.
- `status`  out  8  {`ovr`, `full`, `nempty`, count[4:0]}.
- `irq`  out  1  `ie` & `nempty`.

## Operation
- Ack FSM, two states:
  - `IDLE`: on `rx_rdy`=1, push `rx_data` (or flag overrun) at this edge; go to `ACK`.
  - `ACK`: `rx_done`=1; when `rx_rdy`=0, go to `IDLE`.
  - `rx_done` is held high rather than pulsed, so the handshake completes while the receiver's `enable` is low.
- Push accepted when count < `DEPTH`, or when count = `DEPTH` and `rd`=1 in the same cycle.
- Otherwise the byte is discarded and `ovr` is set (sticky). The byte is still acknowledged.
- Pop (`rd`=1) when empty: ignored; count, pointers and `ovr` unchanged.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Pointers are `AW` bits and wrap modulo `DEPTH`. Count is 5 bits, range 0..`DEPTH`.
- `ctrl_wr`:
  - bit0 and bit3 load `fsel` and `ie`.
  - bit1 (flush) clears pointers, count and `ovr`.
  - bit2 clears `ovr`.
- Flush concurrent with push: flush wins; the byte is dropped, `ovr` is not set, and the FSM still advances to `ACK`.
- Clear-overrun concurrent with an overrunning push: `ovr` ends at 1 (set wins).
- `fsel` change takes effect immediately. A byte in flight may be corrupted; that is software's responsibility.

## Timing
- Reset values: state `IDLE`, `rx_done`=0, `fsel`=0, `ie`=0, `ovr`=0, count 0, `nempty`=0, `full`=0, `irq`=0, `rd_data`=8'h00. FIFO memory is not reset.
- `rx_rdy` rising at edge n (seen in `IDLE`): byte written at edge n+1. `rx_done`, count, `nempty` and `irq` update after edge n+1.
- Receiver clears `rdy` one enabled cycle after seeing `done`. `rx_done` drops on the edge after `rx_rdy` is sampled low.
- Minimum back-to-back byte spacing: 3 cycles, far below one character time.
- Pop: `rd_data` shows the next entry after the edge where `rd` is sampled.
- Reset asserted mid-handshake: FSM returns to `IDLE` and `rx_done` goes to 0. If `rx_rdy` is still 1 after reset, that byte is taken again as a new byte.

## Structure
- Package `rs232_pkg`:
  - state enum (`IDLE`, `ACK`)
  - control bit indices (`CTRL_FSEL`=0, `CTRL_FLUSH`=1, `CTRL_CLROVR`=2, `CTRL_IE`=3)
  - status bit indices (`ST_OVR`=7, `ST_FULL`=6, `ST_NEMPTY`=5)
- Sub-module `rs232_rx_fifo`: synchronous FWFT FIFO with push, pop, flush, count, full and empty.
- The ack FSM, control register and overrun logic live in the top module.

## Test plan
- Reset with all inputs idle → `status`=8'h00, `fsel`=0, `rx_done`=0, `irq`=0.
- Receiver model delivers 8'hA5 → `rx_done` high until `rx_rdy` drops; `status`=8'h21; `rd_data`=8'hA5. `rd` pulse → `status`=8'h00.
- 17 bytes 8'h00..8'h10 with no reads → count 16, `status`=8'hF0, byte 8'h10 dropped. 16 reads return 8'h00..8'h0F in order.
- FIFO full, push coincident with `rd` → pushed byte accepted, count stays 16, `ovr` stays 0.
- `ctrl_wr` 4'b1001 → `fsel`=1, `ie`=1, `irq` asserts on the next received byte. `ctrl_wr` 4'b0010 with 5 entries → count 0, `irq`=0.
- Reset asserted while in `ACK` with `rx_rdy`=1 → `rx_done`=0 next cycle. After release the byte is re-acknowledged and pushed.
